// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns the four raw active-low board push buttons into clean single-cycle
//   move commands for the cursor mover. Each button is synchronised and
//   debounced. The block emits one command per press, and optionally repeats
//   the command while the button is held.
//
//   clk        in   system clock
//   reset      in   asynchronous reset, active-low (0 = reset)
//   raw_btn    in   [3:0] raw buttons, active-low: [3]=up [2]=left [1]=down [0]=right
//   btn_code   out  [3:0] active-low one-cold move code, 4'b1111 when idle
//   btn_valid  out  high for the single cycle btn_code carries a command
//   btn_held   out  [3:0] debounced level per button, active-high
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no key pressed, waiting for a single key
//   S_HOLD   | one key held, counting down to the first repeat
//   S_REPEAT | one key held, repeating every REPEAT_PERIOD cycles
//   S_LOCK   | chord seen; silent until every key is released
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_btn,
  output logic [3:0] btn_code,
  output logic       btn_valid,
  output logic [3:0] btn_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_LOCK} state_t;

  logic [3:0]    sync1, sync2;
  logic [3:0]    pressed_sync;
  logic [3:0]    stable;          // debounced, active-high
  logic [DW-1:0] db_cnt [4];

  state_t        state, next_state;
  logic [3:0]    key, next_key;
  logic [RW-1:0] rpt_cnt, next_cnt;
  logic          emit;
  logic [3:0]    emit_code;
  logic          one_hot;

  // Synchroniser flops rest at 1 so that reset looks like "all released".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  assign pressed_sync = ~sync2;

  // A level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching
  // cycle. Any agreement in between restarts the count, which drops glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pressed_sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= pressed_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign one_hot = (stable != 4'h0) && ((stable & (stable - 4'h1)) == 4'h0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      key       <= 4'h0;
      rpt_cnt   <= '0;
      btn_code  <= 4'hF;
      btn_valid <= 1'b0;
      btn_held  <= 4'h0;
    end else begin
      state     <= next_state;
      key       <= next_key;
      rpt_cnt   <= next_cnt;
      btn_code  <= emit ? emit_code : 4'hF;
      btn_valid <= emit;
      btn_held  <= stable;
    end
  end

  always_comb begin
    next_state = state;
    next_key   = key;
    next_cnt   = rpt_cnt;
    emit       = 1'b0;
    emit_code  = ~key;
    unique case (state)
      S_IDLE: begin
        if (one_hot) begin
          emit       = 1'b1;
          emit_code  = ~stable;
          next_key   = stable;
          next_cnt   = DELAY_LOAD;
          next_state = S_HOLD;
        end else if (stable != 4'h0) begin
          next_state = S_LOCK;
        end
      end
      S_HOLD, S_REPEAT: begin
        // Release is checked first so it beats a repeat due in the same cycle.
        if (stable == 4'h0) begin
          next_state = S_IDLE;
        end else if (stable != key) begin
          next_state = S_LOCK;
        end else if (REPEAT_EN && rpt_cnt == '0) begin
          emit       = 1'b1;
          next_cnt   = PERIOD_LOAD;
          next_state = S_REPEAT;
        end else if (rpt_cnt != '0) begin
          next_cnt = rpt_cnt - 1'b1;
        end
      end
      S_LOCK: begin
        if (stable == 4'h0) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. The stimulus pushes each expected pulse, with its code and
// its cycle number, into a queue. The monitor pops and checks the queue on
// every btn_valid.
module tb_button_conditioner;

  localparam int LAT = 7;   // raw edge to first command

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw_btn = 4'hF;
  logic [3:0] btn_code;
  logic       btn_valid;
  logic [3:0] btn_held;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_btn(raw_btn),
    .btn_code(btn_code),
    .btn_valid(btn_valid),
    .btn_held(btn_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_chk++;
      if (btn_valid !== (btn_code != 4'hF)) begin
        n_fail++;
        $display("FAIL valid_vs_code: valid %b code %b (cycle %0d)", btn_valid, btn_code, cyc);
      end
    end
    if (btn_valid === 1'b1) begin
      n_chk++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL back_to_back: valid high on consecutive cycles (cycle %0d)", cyc);
      end
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: code %b at cycle %0d, none expected", btn_code, cyc);
      end else begin
        e = sbq.pop_front();
        n_chk++;
        if (btn_code !== e.code || cyc != e.at) begin
          n_fail++;
          $display("FAIL pulse: got code %b at cycle %0d, expected %b at cycle %0d",
                   btn_code, cyc, e.code, e.at);
        end
      end
    end
    prev_valid = btn_valid;
  end

  initial begin
    int c;

    // Reset state
    idle(3);
    chk4("reset_code", btn_code, 4'hF);
    chk4("reset_valid", {3'b0, btn_valid}, 4'h0);
    chk4("reset_held", btn_held, 4'h0);
    reset = 1'b1;
    idle(10);
    chk4("post_reset_code", btn_code, 4'hF);
    chk4("post_reset_held", btn_held, 4'h0);

    // 1: single press of up
    c = cyc;
    raw_btn = 4'b0111;
    expect_pulse(4'b0111, c + LAT);
    idle(8);
    chk4("t1_held_pressed", btn_held, 4'b1000);
    idle(2);
    raw_btn = 4'hF;
    idle(10);
    chk4("t1_held_released", btn_held, 4'h0);
    chk4("t1_code_idle", btn_code, 4'hF);

    // 2: glitches of 1, 2 and 3 cycles are rejected
    raw_btn = 4'b1110; idle(1);
    raw_btn = 4'hF;    idle(1);
    raw_btn = 4'b1110; idle(2);
    raw_btn = 4'hF;    idle(1);
    raw_btn = 4'b1110; idle(3);
    raw_btn = 4'hF;
    idle(10);
    chk4("t2_held", btn_held, 4'h0);

    // 3: auto-repeat on down, held 60 cycles
    c = cyc;
    raw_btn = 4'b1101;
    expect_pulse(4'b1101, c + LAT);
    expect_pulse(4'b1101, c + LAT + 20);
    expect_pulse(4'b1101, c + LAT + 28);
    expect_pulse(4'b1101, c + LAT + 36);
    expect_pulse(4'b1101, c + LAT + 44);
    expect_pulse(4'b1101, c + LAT + 52);
    idle(30);
    chk4("t3_held", btn_held, 4'b0010);
    idle(30);
    raw_btn = 4'hF;
    idle(15);
    chk4("t3_held_released", btn_held, 4'h0);

    // 4: chord leads to LOCK, release of one key is silent
    c = cyc;
    raw_btn = 4'b1011;
    expect_pulse(4'b1011, c + LAT);
    idle(5);
    raw_btn = 4'b1010;
    idle(30);
    chk4("t4_held_chord", btn_held, 4'b0101);
    raw_btn = 4'b1110;
    idle(30);
    chk4("t4_held_one_left", btn_held, 4'b0001);
    raw_btn = 4'hF;
    idle(15);
    c = cyc;
    raw_btn = 4'b1110;
    expect_pulse(4'b1110, c + LAT);
    idle(10);
    raw_btn = 4'hF;
    idle(15);

    // 5: two keys pressed in the same cycle
    raw_btn = 4'b0110;
    idle(10);
    chk4("t5_held", btn_held, 4'b1001);
    idle(30);
    raw_btn = 4'hF;
    idle(15);
    chk4("t5_held_released", btn_held, 4'h0);

    // 6: reset in the middle of a hold
    c = cyc;
    raw_btn = 4'b0111;
    expect_pulse(4'b0111, c + LAT);
    idle(10);
    chk4("t6_held_before", btn_held, 4'b1000);
    reset = 1'b0;
    #1;
    chk4("t6_async_code", btn_code, 4'hF);
    chk4("t6_async_valid", {3'b0, btn_valid}, 4'h0);
    chk4("t6_async_held", btn_held, 4'h0);
    idle(3);
    c = cyc;
    reset = 1'b1;
    expect_pulse(4'b0111, c + LAT);
    idle(10);
    chk4("t6_held_after", btn_held, 4'b1000);
    raw_btn = 4'hF;
    idle(15);

    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
